// File: rtl/front_panel_sw_pkg.sv
// -----------------------------------------------------------------------------
// front_panel_sw_pkg
// Shared definitions for the front-panel switch conditioner:
//   - fp_state_e     : conditioner FSM state encoding
//   - SW_* indices   : default panel switch bit ordering
//                      {clear, extd_addr, addr_load, dep, exam, cont} (MSB..LSB)
//   - fp_cnt_width() : width of the shared pulse/lockout counter
// No ports (package).
// -----------------------------------------------------------------------------
package front_panel_sw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_PULSE   = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_RELEASE = 3'd4
  } fp_state_e;

  // Default bit positions of the panel switches in sw_in / sw_pulse.
  localparam int SW_CONT      = 0;
  localparam int SW_EXAM      = 1;
  localparam int SW_DEP       = 2;
  localparam int SW_ADDR_LOAD = 3;
  localparam int SW_EXTD_ADDR = 4;
  localparam int SW_CLEAR     = 5;

  // The one counter serves both the pulse and the lockout phase, so it must
  // hold max(PULSE_LEN, 2**DBNCE_BITS) - 1 without wrapping.
  function automatic int fp_cnt_width(input int pulse_len, input int dbnce_bits);
    int span;
    span = (pulse_len > (1 << dbnce_bits)) ? pulse_len : (1 << dbnce_bits);
    return (span <= 2) ? 1 : $clog2(span);
  endfunction

endpackage

// File: rtl/front_panel_sw_if.sv
// -----------------------------------------------------------------------------
// front_panel_sw_if
// Panel-side bundle of the switch conditioner.
//   sw_in     : raw switch levels (asynchronous to clk)
//   sw_enable : per-channel mask
//   sw_pulse  : captured switch vector, valid while trigger is high
//   trigger   : common strobe, high exactly when sw_pulse != 0
//   sw_active : conditioner is not idle
//   sw_held   : OR of synchronised, enabled inputs
// Modports: master = panel/driver side, slave = conditioner side.
// -----------------------------------------------------------------------------
interface front_panel_sw_if #(
  parameter int NUM_SW = 6
);
  logic [NUM_SW-1:0] sw_in;
  logic [NUM_SW-1:0] sw_enable;
  logic [NUM_SW-1:0] sw_pulse;
  logic              trigger;
  logic              sw_active;
  logic              sw_held;

  modport master (
    output sw_in, sw_enable,
    input  sw_pulse, trigger, sw_active, sw_held
  );

  modport slave (
    input  sw_in, sw_enable,
    output sw_pulse, trigger, sw_active, sw_held
  );
endinterface

// File: rtl/front_panel_sw_sync.sv
// -----------------------------------------------------------------------------
// front_panel_sw_sync
// SYNC_STAGES-deep, NUM_SW-wide synchroniser with asynchronous active-low clear.
//   clk   : destination clock
//   rst_n : asynchronous active-low clear of every stage
//   d     : asynchronous input levels
//   q     : synchronised levels (last stage)
// -----------------------------------------------------------------------------
module front_panel_sw_sync #(
  parameter int NUM_SW      = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_SW-1:0] d,
  output logic [NUM_SW-1:0] q
);

  logic [SYNC_STAGES-1:0][NUM_SW-1:0] stage_q;
  logic [SYNC_STAGES-1:0][NUM_SW-1:0] stage_d;

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign stage_d[gi] = d;
    end else begin : g_chain
      assign stage_d[gi] = stage_q[gi-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/front_panel_sw.sv
// -----------------------------------------------------------------------------
// front_panel_sw
// Front-panel momentary-switch conditioner. Synchronises NUM_SW switches,
// merges presses landing within one cycle of each other, emits a PULSE_LEN
// cycle sw_pulse/trigger, then locks out for 2**DBNCE_BITS cycles and waits
// for every enabled switch to be released.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : front_panel_sw_if.slave (sw_in, sw_enable -> sw_pulse, trigger,
//           sw_active, sw_held)
// Build option: define FP_AUTOREPEAT_EN to re-fire a held switch every
// 2**REPEAT_BITS cycles spent in RELEASE.
// -----------------------------------------------------------------------------
module front_panel_sw
  import front_panel_sw_pkg::*;
#(
  parameter int NUM_SW      = 6,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_LEN   = 3,
  parameter int DBNCE_BITS  = 4,
  parameter int REPEAT_BITS = 6
) (
  input  logic             clk,
  input  logic             reset,
  front_panel_sw_if.slave  bus
);

  localparam int CNT_W = fp_cnt_width(PULSE_LEN, DBNCE_BITS);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'((1 << DBNCE_BITS) - 1);

  if (SYNC_STAGES < 2 || PULSE_LEN < 1 || DBNCE_BITS < 0 || REPEAT_BITS < 1) begin : g_param_guard
    $error("front_panel_sw: illegal parameter combination");
  end

  logic [NUM_SW-1:0] sync_q;
  logic [NUM_SW-1:0] s;

  fp_state_e         state_q, state_d;
  logic [NUM_SW-1:0] latch_q, latch_d;
  logic [NUM_SW-1:0] pulse_q, pulse_d;
  logic              trig_q, trig_d;
  logic              active_q, active_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef FP_AUTOREPEAT_EN
  logic [REPEAT_BITS-1:0] rcnt_q, rcnt_d;
`endif

  front_panel_sw_sync #(
    .NUM_SW      (NUM_SW),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (bus.sw_in),
    .q     (sync_q)
  );

  // Enable is applied after the synchroniser so a mask change acts at once.
  assign s = sync_q & bus.sw_enable;

  always_comb begin
    state_d = state_q;
    latch_d = latch_q;
    pulse_d = pulse_q;
    trig_d  = trig_q;
    cnt_d   = cnt_q;
`ifdef FP_AUTOREPEAT_EN
    rcnt_d  = rcnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Keep ORing during the hand-off cycle so near-simultaneous presses merge.
        latch_d = latch_q | s;
        if (latch_q != '0) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        pulse_d = latch_q;
        trig_d  = |latch_q;
        latch_d = '0;
        cnt_d   = '0;
        state_d = ST_PULSE;
      end
      ST_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          pulse_d = '0;
          trig_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_LOCKOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOCKOUT: begin
        if (cnt_q == LOCK_LAST) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
`ifdef FP_AUTOREPEAT_EN
          rcnt_d  = '0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (s == '0) begin
          state_d = ST_IDLE;
        end
`ifdef FP_AUTOREPEAT_EN
        else if (rcnt_q == '1) begin
          // Held long enough: re-fire with whatever is still held.
          latch_d = s;
          rcnt_d  = '0;
          state_d = ST_CAPTURE;
        end else begin
          rcnt_d = rcnt_q + REPEAT_BITS'(1);
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        latch_d = '0;
        pulse_d = '0;
        trig_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      latch_q  <= '0;
      pulse_q  <= '0;
      trig_q   <= 1'b0;
      active_q <= 1'b0;
      cnt_q    <= '0;
`ifdef FP_AUTOREPEAT_EN
      rcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      latch_q  <= latch_d;
      pulse_q  <= pulse_d;
      trig_q   <= trig_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
`ifdef FP_AUTOREPEAT_EN
      rcnt_q   <= rcnt_d;
`endif
    end
  end

  assign bus.sw_pulse  = pulse_q;
  assign bus.trigger   = trig_q;
  assign bus.sw_active = active_q;
  assign bus.sw_held   = |s;

endmodule

// File: tb/tb_front_panel_sw.sv
// -----------------------------------------------------------------------------
// tb_front_panel_sw
// Directed-vector bench for front_panel_sw (default build, auto-repeat off).
// Stimulus pushes the expected pulse (vector, trigger cycle, width) into a
// queue; a forked monitor pops and compares whenever trigger rises.
// -----------------------------------------------------------------------------
module tb_front_panel_sw;
  import front_panel_sw_pkg::*;

  localparam int N = 6;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  front_panel_sw_if #(.NUM_SW(N)) bus ();

  front_panel_sw #(
    .NUM_SW      (N),
    .SYNC_STAGES (2),
    .PULSE_LEN   (3),
    .DBNCE_BITS  (4),
    .REPEAT_BITS (6)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [N-1:0] vec;
    int           cyc;
    int           len;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Expect a pulse whose trigger is first seen lat negedges from now.
  task automatic expect_pulse(input logic [N-1:0] v, input int lat, input int len);
    exp_t e;
    e.vec = v;
    e.cyc = cyc + lat;
    e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic monitor();
    exp_t cur;
    bit   have = 1'b0;
    bit   in_p = 1'b0;
    int   width = 0;
    forever begin
      @(negedge clk);
      chk("trigger_vs_pulse", {31'b0, bus.trigger}, {31'b0, |bus.sw_pulse});
      if (bus.trigger && !in_p) begin
        in_p  = 1'b1;
        width = 1;
        chk("pending_expectation", {31'b0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          cur  = exp_q.pop_front();
          have = 1'b1;
          chk("pulse_vector", {26'b0, bus.sw_pulse}, {26'b0, cur.vec});
          chk("trigger_cycle", cyc, cur.cyc);
        end else begin
          have = 1'b0;
        end
      end else if (bus.trigger && in_p) begin
        width++;
        if (have) chk("pulse_stable", {26'b0, bus.sw_pulse}, {26'b0, cur.vec});
      end else if (!bus.trigger && in_p) begin
        in_p = 1'b0;
        $display("pulse vec=%b ended at cycle %0d width=%0d", cur.vec, cyc, width);
        if (have) chk("pulse_width", width, cur.len);
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.sw_in     = '0;
    bus.sw_enable = '1;
    fork
      monitor();
    join_none

    // Reset state
    #1;
    chk("rst_trigger", {31'b0, bus.trigger}, 32'd0);
    chk("rst_pulse", {26'b0, bus.sw_pulse}, 32'd0);
    chk("rst_active", {31'b0, bus.sw_active}, 32'd0);
    chk("rst_held", {31'b0, bus.sw_held}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(3);

    // Single press held 40 cycles: one pulse only
    bus.sw_in = 6'b000001 << SW_EXAM;
    expect_pulse(6'b000010, 5, 3);
    tick(40);
    chk("single_held", {31'b0, bus.sw_held}, 32'd1);
    chk("single_active_held", {31'b0, bus.sw_active}, 32'd1);
    chk("single_pulse_idle", {26'b0, bus.sw_pulse}, 32'd0);
    bus.sw_in = '0;
    tick(6);
    chk("single_active_released", {31'b0, bus.sw_active}, 32'd0);
    chk("single_held_released", {31'b0, bus.sw_held}, 32'd0);
    tick(5);

    // Merge: bit0 then bit3 one cycle later
    bus.sw_in = 6'b000001 << SW_CONT;
    expect_pulse(6'b001001, 5, 3);
    tick(1);
    bus.sw_in = bus.sw_in | (6'b000001 << SW_ADDR_LOAD);
    tick(30);
    bus.sw_in = '0;
    tick(10);

    // Mask: masked channel never latched
    bus.sw_enable = 6'b111110;
    bus.sw_in     = 6'b000001;
    tick(30);
    chk("mask_held", {31'b0, bus.sw_held}, 32'd0);
    chk("mask_active", {31'b0, bus.sw_active}, 32'd0);
    bus.sw_in = '0;
    tick(5);
    bus.sw_enable = '1;
    tick(2);

    // Lockout: re-press during lockout is ignored; fresh press needed
    bus.sw_in = 6'b000001 << SW_DEP;
    expect_pulse(6'b000100, 5, 3);
    tick(6);
    bus.sw_in = '0;
    tick(9);
    bus.sw_in = 6'b000001 << SW_EXTD_ADDR;
    tick(30);
    chk("lockout_wait_active", {31'b0, bus.sw_active}, 32'd1);
    chk("lockout_wait_pulse", {26'b0, bus.sw_pulse}, 32'd0);
    bus.sw_in = '0;
    tick(10);
    chk("lockout_idle", {31'b0, bus.sw_active}, 32'd0);
    bus.sw_in = 6'b000001 << SW_EXTD_ADDR;
    expect_pulse(6'b010000, 5, 3);
    tick(30);
    bus.sw_in = '0;
    tick(10);

    // Reset in PULSE cycle 2, switch held through reset
    bus.sw_in = 6'b000001 << SW_CLEAR;
    expect_pulse(6'b100000, 5, 2);
    tick(6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_trigger", {31'b0, bus.trigger}, 32'd0);
    chk("arst_pulse", {26'b0, bus.sw_pulse}, 32'd0);
    chk("arst_active", {31'b0, bus.sw_active}, 32'd0);
    chk("arst_held", {31'b0, bus.sw_held}, 32'd0);
    tick(2);
    chk("arst_hold_trigger", {31'b0, bus.trigger}, 32'd0);
    chk("arst_hold_active", {31'b0, bus.sw_active}, 32'd0);
    rst_n = 1'b1;
    expect_pulse(6'b100000, 5, 3);
    tick(30);
    bus.sw_in = '0;
    tick(20);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
